// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a table of 2-bit saturating counters indexed by PC.
// It predicts taken/not-taken for the instruction in IF. The resolved outcome
// from EX/MEM trains it. It also reports mispredicts and keeps branch and
// mispredict statistics.
//
// Optional feature: define BRANCH_PREDICTOR_GSHARE_EN to XOR an IDX_W-bit
// global history register into both the lookup index and the update index.
//
// Ports:
//   clk_i, rst_i   clock; synchronous active-high reset
//   pc_i           IF-stage PC used for lookup
//   predict_o      combinational prediction for pc_i (counter MSB)
//   upd_valid_i    one resolved conditional branch this cycle
//   upd_pc_i       PC of the resolved branch
//   upd_taken_i    resolved outcome of that branch
//   upd_pred_i     prediction made earlier for that branch
//   mispredict_o   registered one-cycle pulse after a mispredicted update
//   branch_cnt_o   saturating count of valid updates since reset
//   miss_cnt_o     saturating count of mispredicted updates since reset
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             predict_o,
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       table_q [DEPTH];
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_cnt_cur;
  logic [1:0]       upd_cnt_nxt;
  logic             upd_miss;

  // Only the word-aligned index bits of the PCs take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[PC_W-1:IDX_W+2], pc_i[1:0],
                            upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // Both indices use the history as it is before this cycle's shift.
  assign lkp_idx = pc_i[IDX_W+1:2] ^ ghr_q;
  assign upd_idx = upd_pc_i[IDX_W+1:2] ^ ghr_q;

  // Global history: shift in each resolved outcome.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else if (upd_valid_i) begin
      ghr_q <= {ghr_q[IDX_W-2:0], upd_taken_i};
    end
  end
`else
  assign lkp_idx = pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
`endif

  // Zero-latency lookup. A same-cycle update to this entry is not bypassed.
  assign predict_o = table_q[lkp_idx][1];

  assign upd_cnt_cur = table_q[upd_idx];
  assign upd_miss    = upd_pred_i ^ upd_taken_i;

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    upd_cnt_nxt = upd_cnt_cur;
    if (upd_taken_i) begin
      if (upd_cnt_cur != 2'b11) upd_cnt_nxt = upd_cnt_cur + 2'd1;
    end else begin
      if (upd_cnt_cur != 2'b00) upd_cnt_nxt = upd_cnt_cur - 2'd1;
    end
  end

  // Table, mispredict flag and statistics. Reset wins over a same-cycle update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= 2'b01;
      end
      mispredict_o <= 1'b0;
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      mispredict_o <= upd_valid_i & upd_miss;
      if (upd_valid_i) begin
        table_q[upd_idx] <= upd_cnt_nxt;
        if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
        if (upd_miss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
